// File: rtl/read_burst_planner_pkg.sv
// -----------------------------------------------------------------------------
// vdma_len_pkg
// Shared definitions for the VDMA read/write burst planners.
//   state_e     : planner FSM states
//   MODE_LINE   : unit is one active line, repeated vactive times
//   MODE_FRAME  : unit is the whole active frame
//   clog2()     : ceiling log2, used to turn the AXI data width into a shift
// -----------------------------------------------------------------------------
package vdma_len_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC0 = 2'd1,
    ST_CALC1 = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  localparam logic MODE_LINE  = 1'b1;
  localparam logic MODE_FRAME = 1'b0;

  function automatic int clog2(input int value);
    int result = 0;
    int v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/read_burst_planner_if.sv
// -----------------------------------------------------------------------------
// read_burst_planner_if
// Burst request channel from the planner to the AXI read master.
//   req_valid : request valid            (planner -> master)
//   req_ready : master accepts request   (master  -> planner)
//   req_len   : burst length in beats    (planner -> master)
//   req_tail  : last request of the unit (planner -> master)
//   req_eof   : last request of frame    (planner -> master)
// -----------------------------------------------------------------------------
interface read_burst_planner_if #(
  parameter int LSIZE = 9
);
  logic             req_valid;
  logic             req_ready;
  logic [LSIZE-1:0] req_len;
  logic             req_tail;
  logic             req_eof;

  modport master (
    output req_valid,
    output req_len,
    output req_tail,
    output req_eof,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_len,
    input  req_tail,
    input  req_eof,
    output req_ready
  );
endinterface

// File: rtl/read_burst_planner_beat_calc.sv
// -----------------------------------------------------------------------------
// beat_calc
// Two-stage registered beat calculator, shared by read and write planners.
// Stage 1 (on load): pix   = mode_line ? hactive : vactive*hactive
//                    units = mode_line ? vactive : 1
// Stage 2 (next cycle): unit_beats = ceil(pix*DSIZE / AXI_DSIZE), saturated
//                       to CSIZE bits.
// Ports:
//   clock, rst_n          : clock, async active-low reset
//   load                  : capture mode/geometry (frame sync)
//   mode_line, vactive,
//   hactive               : frame geometry
//   unit_beats            : AXI beats per unit (valid two cycles after load)
//   units                 : number of units per frame (same timing)
// -----------------------------------------------------------------------------
module beat_calc
  import vdma_len_pkg::*;
#(
  parameter int AXI_DSIZE = 256,
  parameter int DSIZE     = 24,
  parameter int CSIZE     = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic             mode_line,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  output logic [CSIZE-1:0] unit_beats,
  output logic [15:0]      units
);

  localparam int          SHIFT    = clog2(AXI_DSIZE);
  localparam logic [47:0] LOW_MASK = 48'(AXI_DSIZE - 1);
  localparam logic [47:0] SAT_MAX  = 48'({CSIZE{1'b1}});

  logic [31:0]      pix_q;
  logic [15:0]      units_s1_q;
  logic [47:0]      bits;
  logic [47:0]      beats_wide;
  logic [CSIZE-1:0] beats_sat;
  logic [CSIZE-1:0] unit_beats_q;
  logic [15:0]      units_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pix_q      <= '0;
      units_s1_q <= '0;
    end else if (load) begin
      pix_q      <= (mode_line == MODE_LINE) ? {16'd0, hactive}
                                             : 32'(vactive) * 32'(hactive);
      units_s1_q <= (mode_line == MODE_LINE) ? vactive : 16'd1;
    end
  end

  // Ceiling divide by a power of two: shift, then round up if any
  // discarded bit was set.
  always_comb begin
    bits       = 48'(pix_q) * 48'(DSIZE);
    beats_wide = (bits >> SHIFT) + 48'(|(bits & LOW_MASK));
    beats_sat  = (beats_wide > SAT_MAX) ? {CSIZE{1'b1}} : CSIZE'(beats_wide);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      unit_beats_q <= '0;
      units_q      <= '0;
    end else begin
      unit_beats_q <= beats_sat;
      units_q      <= units_s1_q;
    end
  end

  assign unit_beats = unit_beats_q;
  assign units      = units_q;

endmodule

// File: rtl/read_burst_planner.sv
// -----------------------------------------------------------------------------
// read_burst_planner
// On each frame sync, computes the AXI beat count of one unit (a line or the
// whole frame) and issues full bursts plus one tail per unit to the AXI read
// master. A new fsync aborts any frame in flight and restarts planning.
// Ports:
//   clock, rst_n   : clock, async active-low reset
//   mode_line      : 1 = unit is one line (x vactive), 0 = unit is whole frame
//   vactive,hactive: active lines / active pixels per line (latched on fsync)
//   fsync          : frame start pulse
//   req_if         : burst request channel (valid/ready, len, tail, eof)
//   frame_done     : one-cycle pulse after the final handshake of a frame
//   busy           : high from fsync until frame_done or abort-free completion
//   beats_left     : beats left in the unit, excluding the current request
// -----------------------------------------------------------------------------
module read_burst_planner
  import vdma_len_pkg::*;
#(
  parameter int NOR_BURST_LEN = 200,
  parameter int AXI_DSIZE     = 256,
  parameter int DSIZE         = 24,
  parameter int LSIZE         = 9,
  parameter int CSIZE         = 32
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        mode_line,
  input  logic [15:0]                 vactive,
  input  logic [15:0]                 hactive,
  input  logic                        fsync,
  read_burst_planner_if.master        req_if,
  output logic                        frame_done,
  output logic                        busy,
  output logic [CSIZE-1:0]            beats_left
);

  localparam logic [CSIZE-1:0] NOR_C = CSIZE'(NOR_BURST_LEN);
  localparam logic [LSIZE-1:0] NOR_L = LSIZE'(NOR_BURST_LEN);

  state_e           state_q, state_d;
  logic             req_valid_q, req_valid_d;
  logic [LSIZE-1:0] req_len_q, req_len_d;
  logic             req_tail_q, req_tail_d;
  logic             req_eof_q, req_eof_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic [CSIZE-1:0] rem_q, rem_d;
  logic [15:0]      unit_idx_q, unit_idx_d;

  logic [CSIZE-1:0] unit_beats;
  logic [15:0]      units;

  // Request formation helpers: src is the count of beats still owed in the
  // unit including the request being formed.
  logic             issue;
  logic [CSIZE-1:0] src;
  logic             last_unit;

  beat_calc #(
    .AXI_DSIZE (AXI_DSIZE),
    .DSIZE     (DSIZE),
    .CSIZE     (CSIZE)
  ) u_beat_calc (
    .clock      (clock),
    .rst_n      (rst_n),
    .load       (fsync),
    .mode_line  (mode_line),
    .vactive    (vactive),
    .hactive    (hactive),
    .unit_beats (unit_beats),
    .units      (units)
  );

  function automatic logic [LSIZE-1:0] burst_len(input logic [CSIZE-1:0] r);
    return (r > NOR_C) ? NOR_L : LSIZE'(r);
  endfunction

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_valid_q  <= 1'b0;
      req_len_q    <= '0;
      req_tail_q   <= 1'b0;
      req_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      rem_q        <= '0;
      unit_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      req_len_q    <= req_len_d;
      req_tail_q   <= req_tail_d;
      req_eof_q    <= req_eof_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      rem_q        <= rem_d;
      unit_idx_q   <= unit_idx_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_len_d    = req_len_q;
    req_tail_d   = req_tail_q;
    req_eof_d    = req_eof_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    rem_d        = rem_q;
    unit_idx_d   = unit_idx_q;
    issue        = 1'b0;
    src          = '0;
    last_unit    = 1'b0;

    if (fsync) begin
      // Resync wins over everything: drop the frame silently and recompute.
      state_d     = ST_CALC0;
      req_valid_d = 1'b0;
      busy_d      = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_CALC0: state_d = ST_CALC1;
        ST_CALC1: begin
          if (unit_beats == '0 || units == 16'd0) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            state_d     = ST_ISSUE;
            req_valid_d = 1'b1;
            unit_idx_d  = 16'd0;
            issue       = 1'b1;
            src         = unit_beats;
            last_unit   = (units == 16'd1);
          end
        end
        ST_ISSUE: begin
          if (req_valid_q && req_if.req_ready) begin
            if (!req_tail_q) begin
              issue     = 1'b1;
              src       = rem_q;
              last_unit = (unit_idx_q == units - 16'd1);
            end else if (!req_eof_q) begin
              // Next unit starts immediately so there is no bubble.
              unit_idx_d = unit_idx_q + 16'd1;
              issue      = 1'b1;
              src        = unit_beats;
              last_unit  = (unit_idx_q + 16'd1 == units - 16'd1);
            end else begin
              req_valid_d  = 1'b0;
              frame_done_d = 1'b1;
              busy_d       = 1'b0;
              state_d      = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (issue) begin
      req_len_d  = burst_len(src);
      req_tail_d = (src <= NOR_C);
      req_eof_d  = req_tail_d && last_unit;
      rem_d      = src - CSIZE'(req_len_d);
    end
  end

  assign req_if.req_valid = req_valid_q;
  assign req_if.req_len   = req_len_q;
  assign req_if.req_tail  = req_tail_q;
  assign req_if.req_eof   = req_eof_q;
  assign frame_done       = frame_done_q;
  assign busy             = busy_q;
  assign beats_left       = rem_q;

endmodule

// File: tb/tb_read_burst_planner.sv
// -----------------------------------------------------------------------------
// tb_read_burst_planner
// Directed bench for read_burst_planner. Expected requests are derived from
// frame geometry and queued when a frame is started; each accepted request is
// popped and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_read_burst_planner;

  localparam int NOR   = 200;
  localparam int LSIZE = 9;
  localparam int CSIZE = 32;

  typedef struct packed {
    logic [LSIZE-1:0] len;
    logic             tail;
    logic             eof;
    logic [CSIZE-1:0] bl;
  } req_t;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode_line = 1'b0;
  logic [15:0]      vactive = '0;
  logic [15:0]      hactive = '0;
  logic             fsync = 1'b0;
  logic             frame_done;
  logic             busy;
  logic [CSIZE-1:0] beats_left;

  read_burst_planner_if #(.LSIZE(LSIZE)) bus ();

  read_burst_planner #(
    .NOR_BURST_LEN (NOR),
    .AXI_DSIZE     (256),
    .DSIZE         (24),
    .LSIZE         (LSIZE),
    .CSIZE         (CSIZE)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .mode_line  (mode_line),
    .vactive    (vactive),
    .hactive    (hactive),
    .fsync      (fsync),
    .req_if     (bus),
    .frame_done (frame_done),
    .busy       (busy),
    .beats_left (beats_left)
  );

  always #5 clock = ~clock;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   done_cnt = 0;
  int   hs_cnt = 0;
  req_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected request stream, built from ceil(bits/256) per unit.
  task automatic push_frame(input logic mode, input int v, input int h);
    longint pix, bits, beats, r;
    int     units;
    req_t   e;
    units = mode ? v : 1;
    pix   = mode ? longint'(h) : longint'(v) * longint'(h);
    bits  = pix * 24;
    beats = (bits + 255) / 256;
    exp_q.delete();
    if (beats == 0) units = 0;
    for (int u = 0; u < units; u++) begin
      r = beats;
      while (r > 0) begin
        e.len  = LSIZE'((r > NOR) ? NOR : r);
        r      = r - longint'(e.len);
        e.tail = (r == 0);
        e.eof  = (r == 0) && (u == units - 1);
        e.bl   = CSIZE'(r);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at a falling edge with inputs set; scores a handshake that will
  // happen at the coming rising edge, then advances one cycle.
  task automatic cycle();
    req_t obs, exp;
    if (bus.req_valid && bus.req_ready) begin
      hs_cnt++;
      check("req_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp      = exp_q.pop_front();
        obs.len  = bus.req_len;
        obs.tail = bus.req_tail;
        obs.eof  = bus.req_eof;
        obs.bl   = beats_left;
        check($sformatf("req[%0d]", hs_cnt), 64'(obs), 64'(exp));
      end
    end
    if (frame_done) begin
      done_cnt++;
      check("busy_at_done", 64'(busy), 64'd0);
    end
    @(negedge clock);
  endtask

  // Pulse fsync for one edge; returns at the falling edge of cycle 1.
  task automatic start_frame(input logic mode, input int v, input int h);
    mode_line     = mode;
    vactive       = 16'(v);
    hactive       = 16'(h);
    fsync         = 1'b1;
    bus.req_ready = 1'b0;
    @(negedge clock);
    fsync     = 1'b0;
    mode_line = ~mode;
    vactive   = 16'hdead;
    hactive   = 16'hbeef;
  endtask

  // Waits out cycles 1 and 2, checking the pipeline latency to cycle 3.
  task automatic check_latency(input string tag);
    check({tag, "_busy_c1"}, 64'(busy), 64'd1);
    check({tag, "_valid_c1"}, 64'(bus.req_valid), 64'd0);
    @(negedge clock);
    check({tag, "_valid_c2"}, 64'(bus.req_valid), 64'd0);
    @(negedge clock);
    check({tag, "_valid_c3"}, 64'(bus.req_valid), 64'd1);
  endtask

  task automatic run_frame(input string tag, input int budget);
    int n = 0;
    done_cnt      = 0;
    hs_cnt        = 0;
    bus.req_ready = 1'b1;
    while ((exp_q.size() != 0 || done_cnt == 0) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_in_budget"}, 64'(n < budget), 64'd1);
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_all_reqs"}, 64'(exp_q.size()), 64'd0);
    cycle();
    check({tag, "_done_one_pulse"}, 64'(done_cnt), 64'd1);
    check({tag, "_idle_valid"}, 64'(bus.req_valid), 64'd0);
  endtask

  initial begin
    bus.req_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_valid", 64'(bus.req_valid), 64'd0);
    check("rst_len", 64'(bus.req_len), 64'd0);
    check("rst_tail_eof", 64'({bus.req_tail, bus.req_eof}), 64'd0);
    check("rst_done_busy", 64'({frame_done, busy}), 64'd0);
    check("rst_beats_left", 64'(beats_left), 64'd0);
    rst_n = 1'b1;
    @(negedge clock);

    // Line mode 1920x2: two tail requests of 180 beats.
    push_frame(1'b1, 2, 1920);
    start_frame(1'b1, 2, 1920);
    check_latency("line2");
    check("line2_first_len", 64'(bus.req_len), 64'd180);
    run_frame("line2", 100);

    // Frame mode 1920x1080: 972 bursts, one tail at the end.
    push_frame(1'b0, 1080, 1920);
    check("frame_req_count", 64'(exp_q.size()), 64'd972);
    start_frame(1'b0, 1080, 1920);
    check_latency("frame");
    run_frame("frame", 2000);

    // Line mode 100x1: 2400 bits round up to 10 beats.
    push_frame(1'b1, 1, 100);
    start_frame(1'b1, 1, 100);
    check_latency("small");
    run_frame("small", 50);

    // Backpressure: request must hold for 5 stalled cycles.
    push_frame(1'b1, 2, 1920);
    start_frame(1'b1, 2, 1920);
    check_latency("stall");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_valid[%0d]", i), 64'(bus.req_valid), 64'd1);
      check($sformatf("stall_len[%0d]", i), 64'(bus.req_len), 64'd180);
      @(negedge clock);
    end
    run_frame("stall", 100);

    // Abort during request 3 of a 1080p frame.
    push_frame(1'b0, 1080, 1920);
    start_frame(1'b0, 1080, 1920);
    repeat (2) @(negedge clock);
    done_cnt      = 0;
    hs_cnt        = 0;
    bus.req_ready = 1'b1;
    for (int n = 0; n < 20 && hs_cnt < 2; n++) cycle();
    check("abort_two_hs", 64'(hs_cnt), 64'd2);
    check("abort_req3_bl", 64'(beats_left), 64'd193800);
    push_frame(1'b0, 1080, 1920);
    start_frame(1'b0, 1080, 1920);
    check("abort_no_done_c1", 64'(frame_done), 64'd0);
    check_latency("abort");
    check("abort_restart_len", 64'(bus.req_len), 64'd200);
    check("abort_restart_bl", 64'(beats_left), 64'd194200);
    check("abort_no_done_total", 64'(done_cnt), 64'd0);
    run_frame("restart", 2000);

    // Empty line: frame_done at cycle 3 with no request.
    start_frame(1'b1, 2, 0);
    check("empty_done_c1", 64'(frame_done), 64'd0);
    @(negedge clock);
    check("empty_done_c2", 64'(frame_done), 64'd0);
    @(negedge clock);
    check("empty_done_c3", 64'({frame_done, busy, bus.req_valid}), 64'b100);
    @(negedge clock);
    check("empty_done_c4", 64'(frame_done), 64'd0);

    // Asynchronous reset in the middle of ISSUE.
    start_frame(1'b0, 1080, 1920);
    repeat (3) @(negedge clock);
    check("pre_rst_valid", 64'(bus.req_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 64'({bus.req_valid, bus.req_len, bus.req_tail, bus.req_eof}), 64'd0);
    check("async_rst_misc", 64'({frame_done, busy, beats_left}), 64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("post_rst_idle", 64'({busy, bus.req_valid}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
